vid_to_axis: RTL and testbench
==============================

Name: vid_to_axis

Overview:
- Downstream consumer of the colour-bar pattern generator: samples the raw sync/DE/RGB video bus (hs, vs, de, 8-bit r/g/b) and repacks active pixels into an AXI4-Stream video stream.
- Marks start-of-frame with tuser and end-of-line with tlast.
- Absorbs sink backpressure in an internal FWFT FIFO.
- Reports loss (overflow) because the video source cannot be stalled.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- HS_POL, 1, active level of vid_hs (1 = active-high).
- VS_POL, 1, active level of vid_vs (1 = active-high).
- H_ACTIVE, 1920, expected active pixels per line; used only when LINE_CHK_EN is defined.

Ports:
- clk  in  1  single clock for video input and stream output.
- rst  in  1  synchronous reset, active-high.
- vid_hs  in  1  horizontal sync; polarity set by HS_POL. Not used for framing.
- vid_vs  in  1  vertical sync; polarity set by VS_POL.
- vid_de  in  1  data enable; pixel valid when 1.
- vid_r  in  8  red.
- vid_g  in  8  green.
- vid_b  in  8  blue.
- m_axis_tdata  out  24  pixel {r[23:16], g[15:8], b[7:0]}.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  sink ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- overflow  out  1  sticky: a pixel was dropped.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge), one cycle:
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, overflow=0, fifo_level=0.
  - Internal: FIFO emptied, hold register invalid, sof_pend=0, all input pipeline registers cleared.
  - A reset mid-line or mid-frame discards all buffered pixels. Output restarts only at the next vs active edge; pixels of the partial frame are not emitted.
- Input stage: one register stage on vid_vs/vid_de/rgb; all logic below uses the registered signals.
- vs edge: detected when registered vs goes from inactive to active (per VS_POL). The edge sets sof_pend=1. sof_pend clears when the first pixel of the new frame is pushed into the FIFO with tuser=1.
- Hold register (one-pixel lookahead for tlast):
  - de=1, hold invalid: capture pixel; tag tuser=sof_pend.
  - de=1, hold valid: push hold with last=0, then capture new pixel.
  - de=0, hold valid: push hold with last=1; hold becomes invalid.
  - de=0, hold invalid: idle.
- Latency: a pixel is written to the FIFO 1 cycle after the next registered-DE sample. Input pin to m_axis_tvalid on an empty FIFO = 3 cycles.
- Frame start gating:
  - Before the first vs edge after reset, pixels are discarded. They do not enter the FIFO and do not set overflow.
  - A vs edge while hold is valid is harmless: de=0 during vsync forces the tlast push first.
- FIFO:
  - FWFT, width 26 = {user, last, data}.
  - tvalid = (count != 0). Pop on tvalid && tready.
  - Push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set; it stays 1 until rst.
  - fifo_level = count after the cycle's push/pop. Push and pop together leave count unchanged.
  - Pointers wrap modulo DEPTH.
- AXI rules:
  - tdata/tuser/tlast are stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake.
- vid_hs is registered but does not affect framing; lines are delimited by DE.

Optional Feature:
- Macro: LINE_CHK_EN.
- When defined:
  - Adds output line_err (1 bit, sticky, reset 0).
  - An active-pixel counter (width $clog2(H_ACTIVE)+1) counts pixels captured into hold and resets at each tlast push.
  - At a tlast push, if count != H_ACTIVE, line_err is set. A line of H_ACTIVE+1 pixels sets line_err at that line's end.
- When undefined: no counter, no line_err port; H_ACTIVE is unused.

Test Plan:
- Bench parameters for all cases: DEPTH=16, HS_POL=VS_POL=1, H_ACTIVE=8.
- Basic frame, tready=1: vs pulse, then 2 lines of 8 DE pixels with r=g=b=pixel index 0..7, then vs. Expect 16 beats; beat 0 tuser=1 (only one); beats 7 and 15 tlast=1; tdata=0x000000..0x070707 per line; overflow=0.
- Pre-sync discard: after reset, 1 line of 8 DE pixels, no vs edge. Expect tvalid stays 0, fifo_level=0, overflow=0.
- Backpressure: tready=0 during 1 line of 8 pixels. Expect fifo_level=8 at 3 cycles after the last DE. Then raise tready: 8 beats in order, tlast on beat 8, tdata held stable while stalled.
- Overflow: tready=0 for 3 lines of 8 (24 pixels). Expect fifo_level saturates at 16, overflow=1 and stays 1. After tready=1, exactly 16 beats drained, the first 16 pixels in order.
- Reset mid-line: assert rst after 4 pixels of a line. Expect all outputs 0 next cycle. Next frame after a vs edge starts with tuser=1 and no stale pixels.
- LINE_CHK_EN: line of 7 pixels -> line_err=1 at that tlast push. Separate run with lines of 8 pixels only -> line_err=0.

Source files
------------

// File: rtl/vid_to_axis.sv
// Repacks raw hs/vs/de/RGB video into an AXI4-Stream video stream through an FWFT FIFO with a sticky overflow flag.
// Define LINE_CHK_EN to add a sticky line_err output for lines that are not H_ACTIVE pixels long.
module vid_to_axis #(
  parameter int unsigned DEPTH    = 16,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned H_ACTIVE = 1920
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vid_hs,
  input  logic                       vid_vs,
  input  logic                       vid_de,
  input  logic [7:0]                 vid_r,
  input  logic [7:0]                 vid_g,
  input  logic [7:0]                 vid_b,
  output logic [23:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overflow,
`ifdef LINE_CHK_EN
  output logic                       line_err,
`endif
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 26;

  logic          hs_q, vs_q, de_q, vs_d;
  logic [23:0]   pix_q;
  logic          synced, sof_pend;
  logic          hold_valid, hold_user;
  logic [23:0]   hold_data;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;

  logic          vs_edge, capture, push_req, push_last, push_ok, pop, cap_user;
  logic [EW-1:0] rd_entry;
  logic          unused_hs;

  assign unused_hs = hs_q;

  // Hold register gives one pixel of lookahead so the last pixel of a line can carry tlast.
  assign vs_edge   = vs_q & ~vs_d;
  assign capture   = de_q & synced;
  assign push_req  = hold_valid;
  assign push_last = ~de_q;
  assign pop       = (count != '0) & m_axis_tready;
  assign push_ok   = push_req & ((count < CW'(DEPTH)) | pop);
  assign cap_user  = sof_pend & ~(push_req & hold_user);
  assign rd_entry  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      vs_d       <= 1'b0;
      pix_q      <= '0;
      synced     <= 1'b0;
      sof_pend   <= 1'b0;
      hold_valid <= 1'b0;
      hold_user  <= 1'b0;
      hold_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      hs_q       <= (vid_hs == HS_POL);
      vs_q       <= (vid_vs == VS_POL);
      de_q       <= vid_de;
      vs_d       <= vs_q;
      pix_q      <= {vid_r, vid_g, vid_b};
      hold_valid <= capture;
      if (vs_edge) synced <= 1'b1;
      if (vs_edge) sof_pend <= 1'b1;
      else if (push_req && hold_user) sof_pend <= 1'b0;
      if (capture) begin
        hold_data <= pix_q;
        hold_user <= cap_user;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset; empty entries are masked at the output.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {hold_user, push_last, hold_data};
  end

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? rd_entry[23:0] : 24'h0;
  assign m_axis_tlast  = m_axis_tvalid & rd_entry[24];
  assign m_axis_tuser  = m_axis_tvalid & rd_entry[25];
  assign overflow      = ovf_q;
  assign fifo_level    = count;

`ifdef LINE_CHK_EN
  localparam int unsigned LW = $clog2(H_ACTIVE) + 1;

  logic [LW-1:0] line_cnt;

  // Counts pixels captured into hold; checked and cleared on each tlast push.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
      line_err <= 1'b0;
    end else if (push_req && push_last) begin
      line_cnt <= '0;
      if (line_cnt != LW'(H_ACTIVE)) line_err <= 1'b1;
    end else if (capture && line_cnt != '1) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = H_ACTIVE;
`endif

endmodule

// File: tb/tb_vid_to_axis.sv
// Directed self-checking bench for vid_to_axis: framing, pre-sync discard, backpressure, overflow, reset.
// Build with LINE_CHK_EN defined to also exercise line_err.
module tb_vid_to_axis;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_hs, vid_vs, vid_de;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic        overflow;
  logic [4:0]  fifo_level;
`ifdef LINE_CHK_EN
  logic        line_err;
`endif

  int checks = 0;
  int failures = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t exp_basic[16];
  logic  seen_valid;
  logic [23:0] held;

  vid_to_axis #(.DEPTH(16), .HS_POL(1'b1), .VS_POL(1'b1), .H_ACTIVE(8)) dut (
    .clk(clk), .rst(rst),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .overflow(overflow),
`ifdef LINE_CHK_EN
    .line_err(line_err),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Beats are recorded half a cycle before the edge that completes the handshake.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid) seen_valid <= 1'b1;
    if (!rst && m_axis_tvalid && m_axis_tready)
      got_q.push_back('{data: m_axis_tdata, user: m_axis_tuser, last: m_axis_tlast});
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      vid_de = 1'b1;
      vid_r  = base + 8'(i);
      vid_g  = base + 8'(i);
      vid_b  = base + 8'(i);
      tick();
    end
    vid_de = 1'b0;
    vid_r = 8'h0; vid_g = 8'h0; vid_b = 8'h0;
    vid_hs = 1'b1;
    tick(2);
    vid_hs = 1'b0;
  endtask

  task automatic vs_pulse();
    vid_vs = 1'b1;
    tick(3);
    vid_vs = 1'b0;
    tick(3);
  endtask

  task automatic add_line(input int n, input logic [7:0] base, input logic first_user);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: {3{base + 8'(i)}}, user: first_user && (i == 0), last: (i == n - 1)});
    end
  endtask

  task automatic compare_beats(input string name);
    check({name, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s_data%0d", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
        check($sformatf("%s_user%0d", name, i), 32'(got_q[i].user), 32'(exp_q[i].user));
        check($sformatf("%s_last%0d", name, i), 32'(got_q[i].last), 32'(exp_q[i].last));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    check({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({name, "_tdata"},  32'(m_axis_tdata),  32'd0);
    check({name, "_tuser"},  32'(m_axis_tuser),  32'd0);
    check({name, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({name, "_ovf"},    32'(overflow),      32'd0);
    check({name, "_level"},  32'(fifo_level),    32'd0);
  endtask

  initial begin
    // Two lines of pixel indices 0..7; single tuser at beat 0, tlast closing each line.
    for (int i = 0; i < 16; i++) begin
      exp_basic[i].data = {3{8'(i % 8)}};
      exp_basic[i].user = (i == 0);
      exp_basic[i].last = (i % 8 == 7);
    end

    rst = 1'b1; vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0;
    vid_r = 8'h0; vid_g = 8'h0; vid_b = 8'h0; m_axis_tready = 1'b1;
    seen_valid = 1'b0;
    tick(2);
    check_idle("reset");
`ifdef LINE_CHK_EN
    check("reset_line_err", 32'(line_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Pixels before any vs edge are discarded silently.
    send_line(8, 8'h01);
    tick(4);
    check("presync_seen_valid", 32'(seen_valid), 32'd0);
    check("presync_level", 32'(fifo_level), 32'd0);
    check("presync_ovf", 32'(overflow), 32'd0);
    check("presync_beats", 32'(got_q.size()), 32'd0);
    got_q.delete();

    // Basic frame with tready held high.
    vs_pulse();
    send_line(8, 8'h00);
    tick();
    send_line(8, 8'h00);
    vs_pulse();
    tick(4);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_basic[i]);
    compare_beats("basic");
    check("basic_ovf", 32'(overflow), 32'd0);

    // Backpressure: one line buffered, output held stable, then drained.
    m_axis_tready = 1'b0;
    vs_pulse();
    send_line(8, 8'h10);
    check("bp_level", 32'(fifo_level), 32'd8);
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    held = m_axis_tdata;
    check("bp_head", 32'(held), 32'h101010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_stable%0d", i), 32'(m_axis_tdata), 32'(held));
      check($sformatf("bp_valid%0d", i), 32'(m_axis_tvalid), 32'd1);
    end
    m_axis_tready = 1'b1;
    tick(12);
    add_line(8, 8'h10, 1'b1);
    compare_beats("bp");
    check("bp_level_empty", 32'(fifo_level), 32'd0);

    // Overflow: 24 pixels into a 16-deep FIFO with the sink stalled.
    m_axis_tready = 1'b0;
    vs_pulse();
    send_line(8, 8'h20);
    tick();
    send_line(8, 8'h30);
    check("ovf_level16", 32'(fifo_level), 32'd16);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    tick();
    send_line(8, 8'h40);
    check("ovf_level_sat", 32'(fifo_level), 32'd16);
    check("ovf_set", 32'(overflow), 32'd1);
    m_axis_tready = 1'b1;
    tick(24);
    add_line(8, 8'h20, 1'b1);
    add_line(8, 8'h30, 1'b0);
    compare_beats("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_level_empty", 32'(fifo_level), 32'd0);
`ifdef LINE_CHK_EN
    check("line_err_good", 32'(line_err), 32'd0);
`endif

    // Reset mid-line clears everything; output waits for the next vs edge.
    vs_pulse();
    for (int i = 0; i < 4; i++) begin
      vid_de = 1'b1; vid_r = 8'h90; vid_g = 8'h90; vid_b = 8'h90;
      tick();
    end
    rst = 1'b1;
    tick();
    check_idle("midrst");
    rst = 1'b0;
    vid_de = 1'b0;
    tick();
    got_q.delete();
    seen_valid = 1'b0;
    send_line(8, 8'h60);
    tick(4);
    check("midrst_nosync_beats", 32'(got_q.size()), 32'd0);
    check("midrst_nosync_valid", 32'(seen_valid), 32'd0);
    got_q.delete();
    vs_pulse();
    send_line(8, 8'h70);
    tick(4);
    add_line(8, 8'h70, 1'b1);
    compare_beats("midrst");
    check("midrst_ovf", 32'(overflow), 32'd0);

`ifdef LINE_CHK_EN
    check("line_err_clean", 32'(line_err), 32'd0);
    vs_pulse();
    send_line(7, 8'h80);
    check("line_err_short", 32'(line_err), 32'd1);
    tick(4);
    got_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
